// File: rtl/video_wr_arbiter.sv
// Single write-port scheduler for the video memory: CPU / Wishbone round-robin plus a fill engine.
// Optional VWR_BLANK_ONLY_EN adds a vblank input and confines all writes to vertical blank.
module video_wr_arbiter #(
    parameter int ADDR_W  = 11,
    parameter int COLOR_W = 3
) (
    input  logic               clk,
    input  logic               rst,
`ifdef VWR_BLANK_ONLY_EN
    input  logic               vblank,
`endif
    input  logic               cpu_req,
    input  logic [ADDR_W-1:0]  cpu_addr,
    input  logic [COLOR_W-1:0] cpu_color,
    output logic               cpu_gnt,
    input  logic               wb_req,
    input  logic [ADDR_W-1:0]  wb_addr,
    input  logic [COLOR_W-1:0] wb_color,
    output logic               wb_gnt,
    input  logic               clr_start,
    input  logic [COLOR_W-1:0] clr_color,
    output logic               clr_busy,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [COLOR_W-1:0] mem_color
);
    typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

    localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  cnt, cnt_nxt;
    logic [COLOR_W-1:0] fill_color, fill_color_nxt;
    logic               last_wb, last_wb_nxt;
    logic               cpu_gnt_nxt, wb_gnt_nxt, mem_we_nxt, clr_busy_nxt;
    logic [ADDR_W-1:0]  mem_addr_nxt;
    logic [COLOR_W-1:0] mem_color_nxt;
    logic               wr_ok, cpu_elig, wb_elig, pick_cpu, pick_wb;

`ifdef VWR_BLANK_ONLY_EN
    assign wr_ok = vblank;
`else
    assign wr_ok = 1'b1;
`endif

    // A requester granted this cycle sits out the next one, which makes ties alternate.
    assign cpu_elig = cpu_req && !cpu_gnt && wr_ok;
    assign wb_elig  = wb_req  && !wb_gnt  && wr_ok;
    assign pick_cpu = cpu_elig && (!wb_elig || last_wb);
    assign pick_wb  = wb_elig && (!cpu_elig || !last_wb);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            fill_color <= '0;
            last_wb    <= 1'b1;
            cpu_gnt    <= 1'b0;
            wb_gnt     <= 1'b0;
            clr_busy   <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_color  <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            fill_color <= fill_color_nxt;
            last_wb    <= last_wb_nxt;
            cpu_gnt    <= cpu_gnt_nxt;
            wb_gnt     <= wb_gnt_nxt;
            clr_busy   <= clr_busy_nxt;
            mem_we     <= mem_we_nxt;
            mem_addr   <= mem_addr_nxt;
            mem_color  <= mem_color_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        fill_color_nxt = fill_color;
        last_wb_nxt    = last_wb;
        case (state)
            IDLE: begin
                if (clr_start) begin
                    state_nxt      = FILL;
                    cnt_nxt        = '0;
                    fill_color_nxt = clr_color;
                end else if (pick_cpu) begin
                    last_wb_nxt = 1'b0;
                end else if (pick_wb) begin
                    last_wb_nxt = 1'b1;
                end
            end
            FILL: begin
                // Counter wraps to zero only as the FSM leaves FILL, so there is never a second pass.
                if (wr_ok) begin
                    cnt_nxt = cnt + ADDR_W'(1);
                    if (cnt == CNT_LAST) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cpu_gnt_nxt   = 1'b0;
        wb_gnt_nxt    = 1'b0;
        mem_we_nxt    = 1'b0;
        clr_busy_nxt  = 1'b0;
        mem_addr_nxt  = mem_addr;
        mem_color_nxt = mem_color;
        case (state)
            IDLE: begin
                if (!clr_start) begin
                    if (pick_cpu) begin
                        cpu_gnt_nxt   = 1'b1;
                        mem_we_nxt    = 1'b1;
                        mem_addr_nxt  = cpu_addr;
                        mem_color_nxt = cpu_color;
                    end else if (pick_wb) begin
                        wb_gnt_nxt    = 1'b1;
                        mem_we_nxt    = 1'b1;
                        mem_addr_nxt  = wb_addr;
                        mem_color_nxt = wb_color;
                    end
                end
            end
            FILL: begin
                // Busy tracks the fill writes one-for-one and stays up through a blanking pause.
                clr_busy_nxt = 1'b1;
                if (wr_ok) begin
                    mem_we_nxt    = 1'b1;
                    mem_addr_nxt  = cnt;
                    mem_color_nxt = fill_color;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_video_wr_arbiter.sv
// Bench for video_wr_arbiter: grant vector table, alternation, fill, mid-fill reset,
// with a write scoreboard fed when stimulus is driven.
module tb_video_wr_arbiter;
    localparam int AW = 11;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cpu_req = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [CW-1:0] cpu_color = '0;
    logic          cpu_gnt;
    logic          wb_req = 1'b0;
    logic [AW-1:0] wb_addr = '0;
    logic [CW-1:0] wb_color = '0;
    logic          wb_gnt;
    logic          clr_start = 1'b0;
    logic [CW-1:0] clr_color = '0;
    logic          clr_busy;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [CW-1:0] mem_color;
`ifdef VWR_BLANK_ONLY_EN
    logic          vblank = 1'b1;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [AW+CW-1:0] exp_q[$];
    logic [AW+CW-1:0] sb_exp;

    typedef struct {
        logic          cr;
        logic [AW-1:0] ca;
        logic [CW-1:0] cc;
        logic          wr;
        logic [AW-1:0] wa;
        logic [CW-1:0] wc;
        logic          ecg;
        logic          ewg;
    } vec_t;
    vec_t vecs[14];

    always #5 clk = ~clk;

    video_wr_arbiter #(.ADDR_W(AW), .COLOR_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef VWR_BLANK_ONLY_EN
        .vblank    (vblank),
`endif
        .cpu_req   (cpu_req),
        .cpu_addr  (cpu_addr),
        .cpu_color (cpu_color),
        .cpu_gnt   (cpu_gnt),
        .wb_req    (wb_req),
        .wb_addr   (wb_addr),
        .wb_color  (wb_color),
        .wb_gnt    (wb_gnt),
        .clr_start (clr_start),
        .clr_color (clr_color),
        .clr_busy  (clr_busy),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_color (mem_color)
    );

    // Every observed write must match the oldest expected write.
    always @(negedge clk) begin
        if (mem_we) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: got write addr %h color %0d, required no write", mem_addr, mem_color);
            end else begin
                sb_exp = exp_q.pop_front();
                if ({mem_addr, mem_color} !== sb_exp) begin
                    n_err++;
                    $display("FAIL sb_write: got addr %h color %0d, required addr %h color %0d",
                             mem_addr, mem_color, sb_exp[AW+CW-1:CW], sb_exp[CW-1:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic run_fill(input logic [CW-1:0] col, input int wb_at,
                            output int busy_cnt, output int we_busy, output int gnt_busy,
                            output logic done);
        for (int i = 0; i < (1 << AW); i++) exp_q.push_back({AW'(i), col});
        busy_cnt = 0;
        we_busy  = 0;
        gnt_busy = 0;
        done     = 1'b0;
        clr_start = 1'b1;
        clr_color = col;
        tick();
        clr_start = 1'b0;
        clr_color = ~col;
        for (int c = 0; c < 2300 && !done; c++) begin
            tick();
            if (clr_busy) begin
                busy_cnt++;
                if (mem_we) we_busy++;
                if (cpu_gnt || wb_gnt) gnt_busy++;
                if (busy_cnt == wb_at) begin
                    wb_req   = 1'b1;
                    wb_addr  = 11'h123;
                    wb_color = 3'd6;
                    exp_q.push_back({11'h123, 3'd6});
                end
                // A second start mid-fill must be ignored.
                if (busy_cnt == 500) begin
                    clr_start = 1'b1;
                    clr_color = 3'd5;
                end else begin
                    clr_start = 1'b0;
                end
            end else if (busy_cnt > 0) begin
                done = 1'b1;
            end
        end
    endtask

    initial begin
        int   bc, wc, gc;
        logic done, hit;

        vecs[0]  = '{1'b1, 11'h045, 3'd5, 1'b0, 11'h000, 3'd0, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 11'h000, 3'd0, 1'b0, 11'h000, 3'd0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 11'h000, 3'd0, 1'b0, 11'h000, 3'd0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 11'h111, 3'd1, 1'b1, 11'h222, 3'd2, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 11'h111, 3'd1, 1'b1, 11'h222, 3'd2, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 11'h111, 3'd1, 1'b1, 11'h222, 3'd2, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 11'h000, 3'd0, 1'b0, 11'h000, 3'd0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 11'h000, 3'd0, 1'b1, 11'h7FF, 3'd7, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 11'h000, 3'd0, 1'b1, 11'h7FF, 3'd7, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 11'h000, 3'd0, 1'b1, 11'h7FF, 3'd7, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 11'h000, 3'd0, 1'b0, 11'h000, 3'd0, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 11'h3A5, 3'd6, 1'b1, 11'h05A, 3'd3, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 11'h3A5, 3'd6, 1'b1, 11'h05A, 3'd3, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 11'h000, 3'd0, 1'b0, 11'h000, 3'd0, 1'b0, 1'b0};

        // Reset state, with a request pending that must not leak through.
        cpu_req  = 1'b1;
        cpu_addr = 11'h0F0;
        tick();
        tick();
        check("rst_cpu_gnt", cpu_gnt, 0);
        check("rst_wb_gnt", wb_gnt, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_clr_busy", clr_busy, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_color", mem_color, 0);
        cpu_req = 1'b0;
        rst = 1'b0;

        foreach (vecs[i]) begin
            cpu_req = vecs[i].cr; cpu_addr = vecs[i].ca; cpu_color = vecs[i].cc;
            wb_req  = vecs[i].wr; wb_addr  = vecs[i].wa; wb_color  = vecs[i].wc;
            if (vecs[i].ecg) exp_q.push_back({vecs[i].ca, vecs[i].cc});
            else if (vecs[i].ewg) exp_q.push_back({vecs[i].wa, vecs[i].wc});
            tick();
            check($sformatf("vec%0d_cpu_gnt", i), cpu_gnt, vecs[i].ecg);
            check($sformatf("vec%0d_wb_gnt", i), wb_gnt, vecs[i].ewg);
            check($sformatf("vec%0d_mem_we", i), mem_we, vecs[i].ecg | vecs[i].ewg);
        end

        // After reset the CPU wins the first tie, then strict alternation.
        do_reset();
        cpu_req = 1'b1; cpu_addr = 11'h0AA; cpu_color = 3'd4;
        wb_req  = 1'b1; wb_addr  = 11'h155; wb_color  = 3'd3;
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) exp_q.push_back({11'h0AA, 3'd4});
            else exp_q.push_back({11'h155, 3'd3});
            tick();
            check($sformatf("alt%0d_cpu_gnt", i), cpu_gnt, (i % 2 == 0));
            check($sformatf("alt%0d_wb_gnt", i), wb_gnt, (i % 2 == 1));
        end
        cpu_req = 1'b0;
        wb_req  = 1'b0;
        tick();
        check("alt_idle_we", mem_we, 0);

        // Full fill with a WB request parked from write 100.
        run_fill(3'd2, 100, bc, wc, gc, done);
        check("fill1_done", done, 1);
        check("fill1_busy_cycles", bc, 2048);
        check("fill1_we_cycles", wc, 2048);
        check("fill1_grants_during", gc, 0);
        check("fill1_wb_gnt_after", wb_gnt, 1);
        check("fill1_we_after", mem_we, 1);
        wb_req = 1'b0;
        tick();
        check("fill1_wb_gnt_once", wb_gnt, 0);
        check("fill1_idle_we", mem_we, 0);

        // Asynchronous reset while the fill is at 0x300.
        for (int i = 0; i < 12'h300; i++) exp_q.push_back({AW'(i), 3'd4});
        clr_start = 1'b1;
        clr_color = 3'd4;
        tick();
        clr_start = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 1000 && !hit; c++) begin
            tick();
            if (mem_we && mem_addr == 11'h300) hit = 1'b1;
        end
        check("midrst_reached", hit, 1);
        rst = 1'b1;
        #1;
        check("midrst_mem_we", mem_we, 0);
        check("midrst_mem_addr", mem_addr, 0);
        check("midrst_mem_color", mem_color, 0);
        check("midrst_clr_busy", clr_busy, 0);
        check("midrst_gnts", {cpu_gnt, wb_gnt}, 0);
        check("midrst_sb_level", exp_q.size(), 0);
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
        cpu_req = 1'b1; cpu_addr = 11'h2C3; cpu_color = 3'd1;
        exp_q.push_back({11'h2C3, 3'd1});
        tick();
        check("postrst_cpu_gnt", cpu_gnt, 1);
        cpu_req = 1'b0;
        tick();
        check("postrst_cpu_gnt_drop", cpu_gnt, 0);
        run_fill(3'd6, -1, bc, wc, gc, done);
        check("fill2_done", done, 1);
        check("fill2_busy_cycles", bc, 2048);
        check("fill2_we_cycles", wc, 2048);
        check("fill2_idle_we", mem_we, 0);

`ifdef VWR_BLANK_ONLY_EN
        vblank = 1'b0;
        cpu_req = 1'b1; cpu_addr = 11'h010; cpu_color = 3'd2;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("blank%0d_no_write", i), {cpu_gnt, mem_we}, 0);
        end
        vblank = 1'b1;
        exp_q.push_back({11'h010, 3'd2});
        tick();
        check("blank_cpu_gnt", cpu_gnt, 1);
        cpu_req = 1'b0;
        tick();
`endif

        tick();
        check("sb_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/video_wr_arbiter.md
Name: video_wr_arbiter

Overview:
- Single-write-port scheduler for the 2048x3 video memory (address {row[4:0], col[5:0]}).
- Shares the write port between two requesters:
  - the processor I/O path (col/row/color registers);
  - the Wishbone host path.
- Adds a hardware screen-fill engine.
- Sits between the requesters and the video memory write port. The VGA read side is untouched.

Parameters:
- ADDR_W, 11, video memory address width; fill covers 0 .. 2^ADDR_W-1.
- COLOR_W, 3, pixel colour width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- cpu_req  in  1  processor write request, level; held until cpu_gnt.
- cpu_addr  in  ADDR_W  processor pixel address, stable while cpu_req=1.
- cpu_color  in  COLOR_W  processor pixel colour.
- cpu_gnt  out  1  one-cycle grant pulse, registered.
- wb_req  in  1  Wishbone write request, level; held until wb_gnt.
- wb_addr  in  ADDR_W  Wishbone pixel address.
- wb_color  in  COLOR_W  Wishbone pixel colour.
- wb_gnt  out  1  one-cycle grant pulse, registered.
- clr_start  in  1  one-cycle pulse; starts the fill.
- clr_color  in  COLOR_W  fill colour, sampled with clr_start.
- clr_busy  out  1  fill in progress.
- mem_we  out  1  video memory write enable, registered.
- mem_addr  out  ADDR_W  video memory write address, registered.
- mem_color  out  COLOR_W  video memory write data, registered.

Behaviour:
- Reset:
  - Clock clk; reset rst, asynchronous, active-high.
  - All outputs are 0 while rst is high.
  - FSM = IDLE, fill counter = 0, round-robin pointer = "WB last granted".
- Eligibility:
  - A requester is eligible when its req=1 and its gnt is not currently high.
  - A requester therefore cannot be granted on two consecutive cycles.
- IDLE arbitration, evaluated each cycle; results appear at the next clock edge:
  - clr_start=1 takes priority:
    - latch clr_color, counter<=0, FSM<=FILL;
    - no grant this cycle;
    - pending requests stay pending.
  - Otherwise, with exactly one eligible requester:
    - its gnt<=1, mem_we<=1;
    - mem_addr/mem_color <= that requester's addr/color;
    - pointer <= that requester.
  - Both eligible: grant the one not named by the pointer (strict alternation). After reset, CPU wins the first tie.
  - None eligible: mem_we<=0, both gnt<=0.
- Grant timing:
  - gnt and mem_we are asserted in the same cycle; write latency from the req sample is 1 clock.
  - The requester may drop req on the cycle after gnt.
- FILL state:
  - clr_busy=1 from the cycle after clr_start through the cycle carrying the last write.
  - Each cycle: mem_we=1, mem_addr=counter, mem_color=latched colour; counter increments.
  - After address 2^ADDR_W-1 is written, FSM<=IDLE. clr_busy and mem_we drop on the following cycle.
  - Counter never wraps into a second pass.
  - No grants are issued during FILL; clr_start is ignored during FILL.
  - Requests held across FILL are serviced by normal arbitration after return to IDLE.
- Reset mid-fill: immediate return to IDLE. Nothing resumes; the partial fill is left in memory.
- Fill duration: exactly 2^ADDR_W write cycles (2048 at the default).

Optional Feature:
- Macro: VWR_BLANK_ONLY_EN.
- When defined:
  - Adds input port vblank (1 bit), from the VGA controller vertical-blank flag.
  - No grant and no mem_we while vblank=0.
  - Fill pauses with counter and latched colour held, clr_busy staying 1, and resumes when vblank=1.
  - Arbitration and the pointer are frozen while vblank=0.
- When undefined:
  - No vblank port.
  - Writes are issued whenever the rules above allow.

Test Plan:
- Reset, then cpu_req=1, cpu_addr=0x045, cpu_color=3'b101 -> next cycle: cpu_gnt=1, mem_we=1, mem_addr=0x045, mem_color=5; one write only.
- cpu_req and wb_req both held high for 6 cycles -> grants alternate CPU, WB, CPU, ... with gnt on consecutive cycles. Each write carries the granted source's addr/color.
- clr_start pulse with clr_color=2 -> 2048 consecutive mem_we cycles, addresses 0x000..0x7FF ascending, colour 2. clr_busy high for exactly 2048 cycles, then 0.
- wb_req raised at fill write 100 and held -> no wb_gnt during fill; wb_gnt on the first cycle after clr_busy falls.
- rst asserted at fill address 0x300 -> all outputs 0 immediately. After release, a cpu_req is granted normally, and clr_start restarts from 0x000.
- With VWR_BLANK_ONLY_EN, vblank=0 and cpu_req=1 for 10 cycles -> no grant; vblank rises -> cpu_gnt on the next cycle.
